// File: rtl/divider40_20.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, radix-2 restoring on magnitudes,
// one quotient bit per clock followed by a sign fix-up cycle.
module divider40_20 #(
    parameter int W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [2*W-1:0] n,
    input  logic signed [W-1:0]   d,
    output logic                  ready,
    output logic                  valid,
    output logic signed [2*W-1:0] q,
    output logic signed [W-1:0]   r,
    output logic                  dz,
    output logic                  ovf
);
    localparam int CW = $clog2(2*W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  work;      // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [W-1:0]    rem;
    logic [W-1:0]    dmag;
    logic [W-1:0]    n_low;
    logic            sign_q, sign_r, dz_lat;
    logic            accept;
    logic [W:0]      rem_sh;
    logic            ge;
    logic [W-1:0]    diff;

    // Magnitudes are formed one bit wider so the most negative value negates exactly.
    function automatic logic [2*W-1:0] mag_n(input logic signed [2*W-1:0] x);
        logic [2*W:0] ext;
        ext = {x[2*W-1], x};
        if (x[2*W-1]) ext = -ext;
        return ext[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] mag_d(input logic signed [W-1:0] x);
        logic [W:0] ext;
        ext = {x[W-1], x};
        if (x[W-1]) ext = -ext;
        return ext[W-1:0];
    endfunction

    assign ready  = (state == IDLE);
    assign accept = start && ready;

    // Trial subtraction; a successful difference is below |D| so its low W bits are exact.
    assign rem_sh = {rem, work[2*W-1]};
    assign ge     = (rem_sh >= {1'b0, dmag});
    assign diff   = rem_sh[W-1:0] - dmag;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(2*W-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= (state == FIX);
            if (accept)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + CW'(1);
            if (state == FIX) begin
                dz  <= dz_lat;
                // Only a positive quotient of magnitude 2^(2W-1) is unrepresentable.
                ovf <= !dz_lat && work[2*W-1] && !sign_q;
                if (dz_lat) begin
                    q <= '1;
                    r <= n_low;
                end else begin
                    q <= sign_q ? -work : work;
                    r <= sign_r ? -rem : rem;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            work   <= mag_n(n);
            dmag   <= mag_d(d);
            n_low  <= n[W-1:0];
            sign_q <= n[2*W-1] ^ d[W-1];
            sign_r <= n[2*W-1];
            dz_lat <= (d == '0);
            rem    <= '0;
        end else if (state == CALC) begin
            work <= {work[2*W-2:0], ge};
            rem  <= ge ? diff : rem_sh[W-1:0];
        end
    end

endmodule

// File: tb/tb_divider40_20.sv
// Scoreboard bench for divider40_20: expected results are queued at acceptance and
// compared when VALID pulses.
module tb_divider40_20;
    localparam int W   = 20;
    localparam int NRT = 1000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic signed [2*W-1:0] n;
    logic signed [W-1:0]   d;
    logic                  ready, valid;
    logic signed [2*W-1:0] q;
    logic signed [W-1:0]   r;
    logic                  dz, ovf;

    int          checks = 0;
    int          passed = 0;
    logic [61:0] sb[$];
    longint      cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider40_20 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .d(d),
        .ready(ready), .valid(valid), .q(q), .r(r), .dz(dz), .ovf(ovf)
    );

    function automatic logic [61:0] pack(input logic signed [39:0] qv, input logic signed [19:0] rv,
                                         input logic dzv, input logic ovv);
        return {qv, rv, dzv, ovv};
    endfunction

    // Reference division using the simulator's own 64-bit arithmetic.
    function automatic logic [61:0] model(input logic signed [39:0] nv, input logic signed [19:0] dv);
        longint      nl, dl, ql, rl;
        logic [39:0] qv;
        logic [19:0] rv;
        nl = nv;
        dl = dv;
        if (dl == 0) return pack(-40'sd1, nv[19:0], 1'b1, 1'b0);
        if (nl == -(longint'(1) <<< 39) && dl == -1) return pack(40'sh80_0000_0000, 20'sd0, 1'b0, 1'b1);
        ql = nl / dl;
        rl = nl % dl;
        qv = ql[39:0];
        rv = rl[19:0];
        return pack(qv, rv, 1'b0, 1'b0);
    endfunction

    task automatic start_op(input logic signed [39:0] nv, input logic signed [19:0] dv,
                            input logic [61:0] exp);
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n = nv;
        d = dv;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(exp);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!valid && lat < 100);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; n = '0; d = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, valid, q, r, dz, ovf} !== {2'b10, 62'd0})
            $display("FAIL reset_hold: got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 others 0",
                     ready, valid, q, r, dz, ovf);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, valid, q, r, dz, ovf} !== {2'b10, 62'd0})
            $display("FAIL reset_release: got rdy=%b vld=%b q=%h r=%h, want rdy=1 others 0",
                     ready, valid, q, r);
        else passed++;
    endtask

    task automatic test_exact;
        int lat;
        logic [61:0] exp;
        start_op(-40'sd97406784, -20'sd789, pack(40'sd123456, 20'sd0, 1'b0, 1'b0));
        checks++;
        if (ready !== 1'b0) $display("FAIL exact_busy: ready=%b want 0", ready);
        else passed++;
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 41) $display("FAIL exact_latency: got %0d want 41", lat);
        else passed++;
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL exact_result: got vld=%b %h want %h", valid, {q, r, dz, ovf}, exp);
        else passed++;
        checks++;
        if (ready !== 1'b1) $display("FAIL exact_ready: ready=%b want 1", ready);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0 || {q, r, dz, ovf} !== exp)
            $display("FAIL exact_hold: vld=%b out=%h want vld=0 out=%h", valid, {q, r, dz, ovf}, exp);
        else passed++;
    endtask

    task automatic test_signs;
        logic signed [39:0] tn[6];
        logic signed [19:0] td[6];
        logic [61:0]        te[6];
        int lat;
        logic [61:0] exp;
        tn[0] = 40'sd1000001;  td[0] = 20'sd7;  te[0] = pack(40'sd142857, 20'sd2, 1'b0, 1'b0);
        tn[1] = -40'sd1000001; td[1] = 20'sd7;  te[1] = pack(-40'sd142857, -20'sd2, 1'b0, 1'b0);
        tn[2] = 40'sd1000001;  td[2] = -20'sd7; te[2] = pack(-40'sd142857, 20'sd2, 1'b0, 1'b0);
        tn[3] = -40'sd1000001; td[3] = -20'sd7; te[3] = model(-40'sd1000001, -20'sd7);
        tn[4] = 40'sd5;        td[4] = 20'sd9;  te[4] = model(40'sd5, 20'sd9);
        tn[5] = 40'sh12_3456_789A; td[5] = -20'sd524288; te[5] = model(40'sh12_3456_789A, -20'sd524288);
        for (int i = 0; i < 6; i++) begin
            start_op(tn[i], td[i], te[i]);
            wait_valid(lat);
            exp = sb.pop_front();
            checks++;
            if (!valid || lat != 41 || {q, r, dz, ovf} !== exp)
                $display("FAIL signs_%0d: got vld=%b lat=%0d q=%0d r=%0d dz=%b ovf=%b, want %h",
                         i, valid, lat, q, r, dz, ovf, exp);
            else passed++;
        end
    endtask

    task automatic test_div_zero;
        int lat;
        logic [61:0] exp;
        start_op(40'sd12345, 20'sd0, pack(40'shFF_FFFF_FFFF, 20'sd12345, 1'b1, 1'b0));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 41) $display("FAIL dz_latency: got %0d want 41", lat);
        else passed++;
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL dz_pos: got q=%h r=%h dz=%b ovf=%b want %h", q, r, dz, ovf, exp);
        else passed++;
        start_op(-40'sd5, 20'sd0, pack(-40'sd1, -20'sd5, 1'b1, 1'b0));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL dz_neg: got q=%h r=%h dz=%b ovf=%b want %h", q, r, dz, ovf, exp);
        else passed++;
    endtask

    task automatic test_overflow;
        int lat;
        logic [61:0] exp;
        start_op(40'sh80_0000_0000, -20'sd1, pack(40'sh80_0000_0000, 20'sd0, 1'b0, 1'b1));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL ovf_min: got q=%h r=%h dz=%b ovf=%b want %h", q, r, dz, ovf, exp);
        else passed++;
        start_op(40'sh7F_FFFF_FFFF, -20'sd524288, pack(40'shFF_FFF0_0001, 20'sd524287, 1'b0, 1'b0));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL ovf_max: got q=%h r=%h dz=%b ovf=%b want %h", q, r, dz, ovf, exp);
        else passed++;
        start_op(40'sh80_0000_0000, 20'sd1, pack(40'sh80_0000_0000, 20'sd0, 1'b0, 1'b0));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (!valid || {q, r, dz, ovf} !== exp)
            $display("FAIL ovf_minpos: got q=%h r=%h dz=%b ovf=%b want %h", q, r, dz, ovf, exp);
        else passed++;
    endtask

    task automatic test_busy_start;
        int pulses = 0;
        int first_e = 0;
        logic [61:0] got = '0;
        logic [61:0] exp;
        start_op(40'sd1000001, 20'sd7, pack(40'sd142857, 20'sd2, 1'b0, 1'b0));
        for (int e = 1; e <= 45; e++) begin
            if (e == 5 || e == 20) begin
                n = 40'sd999; d = 20'sd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (valid) begin
                pulses++;
                if (first_e == 0) begin
                    first_e = e;
                    got = {q, r, dz, ovf};
                end
            end
        end
        start = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (pulses !== 1 || first_e !== 41)
            $display("FAIL busy_pulses: got %0d pulses first at e%0d, want 1 at e41", pulses, first_e);
        else passed++;
        checks++;
        if (got !== exp) $display("FAIL busy_result: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [61:0] exp;
        start_op(-40'sd1000001, 20'sd7, pack(-40'sd142857, -20'sd2, 1'b0, 1'b0));
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({ready, valid, q, r, dz, ovf} !== {2'b10, 62'd0})
            $display("FAIL midreset: got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 others 0",
                     ready, valid, q, r, dz, ovf);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        start_op(-40'sd1000001, -20'sd7, pack(40'sd142857, -20'sd2, 1'b0, 1'b0));
        wait_valid(lat);
        exp = sb.pop_front();
        checks++;
        if (!valid || lat != 41 || {q, r, dz, ovf} !== exp)
            $display("FAIL midreset_after: got vld=%b lat=%0d out=%h want %h", valid, lat, {q, r, dz, ovf}, exp);
        else passed++;
    endtask

    task automatic test_round_trip;
        logic signed [19:0] a, b;
        longint      p;
        logic [61:0] exp_cur, exp;
        int          lat;
        int          bad_period = 0;
        longint      last_valid = -1;
        for (int i = 0; i < NRT; i++) begin
            if (i == 0) begin
                a = -20'sd524288; b = 20'sd524287;
            end else if (i == 1) begin
                a = 20'sd524287;  b = -20'sd524288;
            end else if (i == 2) begin
                a = -20'sd524288; b = -20'sd524288;
            end else begin
                a = 20'($urandom_range(0, 20'hFFFFF));
                b = 20'($urandom_range(0, 20'hFFFFF));
                if (a == 0) a = 20'sd1;
                if (b == 0) b = -20'sd1;
            end
            p = longint'(a) * longint'(b);
            exp_cur = pack(a, 20'sd0, 1'b0, 1'b0);
            if (i == 0) begin
                @(negedge clk);
                n = p[39:0]; d = b; start = 1'b1;
            end else begin
                n = p[39:0]; d = b;
            end
            @(posedge clk);
            sb.push_back(exp_cur);
            #1;
            wait_valid(lat);
            exp = sb.pop_front();
            checks++;
            if (!valid || {q, r, dz, ovf} !== exp)
                $display("FAIL roundtrip_%0d: a=%0d b=%0d got q=%0d r=%0d dz=%b ovf=%b vld=%b",
                         i, a, b, q, r, dz, ovf, valid);
            else passed++;
            if (last_valid >= 0 && cyc - last_valid != 42) bad_period++;
            last_valid = cyc;
        end
        start = 1'b0;
        checks++;
        if (bad_period != 0) $display("FAIL roundtrip_period: %0d results not 42 cycles apart, want 0", bad_period);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_exact();
        test_signs();
        test_div_zero();
        test_overflow();
        test_busy_start();
        test_reset_mid();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
